// File: rtl/vga_scan_compositor.sv
// vga_scan_compositor: 640x480@60 raster timing master and registered colour/sync output stage.
// Optional frame counter output is enabled by defining VGA_FRAME_CNT_EN.
module vga_scan_compositor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  posx,
    output logic [9:0]  posy,
    input  logic        sprite_visible,
    input  logic [23:0] sprite_rgb,
    input  logic [23:0] bg_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        sync_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]  frame_cnt
`endif
);
    localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FROM = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_TO   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FROM = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_TO   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]  hcnt, vcnt, h_nxt, v_nxt;
    logic [2:0]  raw, dly;
    logic [23:0] rgb;

    assign h_nxt = (hcnt == H_LAST) ? 10'd0 : hcnt + 10'd1;
    assign v_nxt = (hcnt != H_LAST) ? vcnt : (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt        <= 10'd0;
            vcnt        <= 10'd0;
            frame_start <= 1'b1;
        end else begin
            hcnt        <= h_nxt;
            vcnt        <= v_nxt;
            frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
        end
    end

    assign posx = hcnt;
    assign posy = vcnt;

    // {active, hsync, vsync}; delay stages idle at 3'b011 (inactive, syncs high)
    assign raw = {(hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE)),
                  !(hcnt >= HS_FROM && hcnt <= HS_TO),
                  !(vcnt >= VS_FROM && vcnt <= VS_TO)};

    generate
        if (PIPE == 0) begin : g_nopipe
            assign dly = raw;
        end else begin : g_pipe
            logic [2:0] sr [PIPE];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE; i++) sr[i] <= 3'b011;
                end else begin
                    sr[0] <= raw;
                    for (int i = 1; i < PIPE; i++) sr[i] <= sr[i-1];
                end
            end
            assign dly = sr[PIPE-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {blank_n, hsync, vsync} <= 3'b011;
            rgb                     <= 24'h0;
        end else begin
            {blank_n, hsync, vsync} <= dly;
            rgb                     <= dly[2] ? (sprite_visible ? sprite_rgb : bg_rgb) : 24'h0;
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb;
    assign sync_n = 1'b0;

`ifdef VGA_FRAME_CNT_EN
    // the frame_start seen straight out of reset does not count
    logic seen;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen      <= 1'b0;
            frame_cnt <= 8'd0;
        end else if (frame_start) begin
            seen      <= 1'b1;
            frame_cnt <= seen ? frame_cnt + 8'd1 : frame_cnt;
        end
    end
`endif
endmodule

// File: doc/vga_scan_compositor.md
# vga_scan_compositor

Pixel-timing master and final colour stage of the VGA path. Generates 640x480@60 raster timing from a 25 MHz pixel clock, drives the current pixel coordinates (`posx`, `posy`) to the sprite renderers, and registers their `visible`/RGB responses into the DAC colour and sync outputs. Sync and blank are delayed to match sprite-ROM read latency so that colour and timing leave the block aligned.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `PIPE`, 1, sprite response latency in clocks, 0..4

Ports:
- `clk` input 1: pixel clock, 25 MHz, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `posx` output 10: current horizontal counter
- `posy` output 10: current vertical counter
- `sprite_visible` input 1: sprite covers the pixel issued `PIPE` clocks earlier
- `sprite_rgb` input 24: sprite colour {R,G,B}, same timing as `sprite_visible`
- `bg_rgb` input 24: background colour, same timing
- `hsync`, `vsync` output 1 each: active-low sync
- `blank_n` output 1: high during active video
- `sync_n` output 1: constant 0 (no sync-on-green)
- `vga_r`, `vga_g`, `vga_b` output 8 each: pixel colour
- `frame_start` output 1: one-clock pulse at pixel (0,0), undelayed

## Operation
- hcnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800), incrementing every clock, wrapping to 0. vcnt increments when hcnt wraps, 0..V_TOTAL-1 (525), wrapping to 0 when both wrap.
- `posx` = hcnt, `posy` = vcnt, driven directly from the registers.
- Raw timing from counters: active = hcnt < H_ACTIVE and vcnt < V_ACTIVE; hsync_raw low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751); vsync_raw low for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), for the whole line.
- active, hsync_raw and vsync_raw pass through a `PIPE`-stage shift register, then one output register.
- Colour register: if the delayed active is 0, the colour is 0x000000. Otherwise it is `sprite_rgb` when `sprite_visible` is 1, else `bg_rgb`.
- `frame_start` = (hcnt==0 && vcnt==0), registered with the counters. It is not delayed.

## Timing
- The clock in which `posx`=n is presented is cycle n. The sprite inputs for that pixel are sampled at cycle n+PIPE. Colour, `hsync`, `vsync` and `blank_n` for that pixel are valid at cycle n+PIPE+1.
- After `rst_n` deasserts, the first clock presents (0,0) and `frame_start`=1.
- Reset values, applied asynchronously:
  - hcnt=vcnt=0, so `posx`=`posy`=0 and `frame_start`=1.
  - `hsync`=`vsync`=1.
  - `blank_n`=0.
  - RGB=0.
  - All delay stages are set to inactive (active=0, syncs=1).
- Reset mid-frame: all state returns immediately to the reset values. The partial frame is abandoned, and no sync glitch low is emitted.
- Counter wrap 799→0 and 524→0 occur in the same clock as the line/frame end. There is no idle cycle.
- Sprite inputs are ignored (colour forced to 0) whenever the delayed active is 0, including `sprite_visible`=1 during porches.

## Configuration
- `VGA_FRAME_CNT_EN` defined:
  - Adds output `frame_cnt` [7:0]. It resets to 0 and increments (mod 256) in the clock after `frame_start`=1, except for the first `frame_start` after reset.
  - Sprite animation logic uses it.
- Not defined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 for 5 clocks → `hsync`=`vsync`=1, `blank_n`=0, RGB=0, `posx`=`posy`=0, `frame_start`=1. Release → `posx` steps 0,1,2,… per clock.
- Line timing with PIPE=1: `hsync` low exactly on cycles 658..753 of line 0. `blank_n`=1 on cycles 2..641. `posx` wraps 799→0 at cycle 800 and `posy` becomes 1.
- Frame timing with PIPE=1: `vsync` low from cycle 490·800+2 through 492·800+1. `frame_start` pulses at cycles 0 and 420000 only.
- Compositing: `bg_rgb`=0x0000FF, `sprite_visible`=1 with `sprite_rgb`=0xFF0000 for pixels 100..163 of line 10 only.
  - Those pixels output R=FF,G=00,B=00.
  - Other active pixels output B=FF.
  - `sprite_visible`=1 during hcnt 700 outputs 0x000000.
- Mid-frame reset: assert `rst_n`=0 at line 200, pixel 300 for 1 clock.
  - Outputs go to reset values asynchronously.
  - After release, the next `hsync` low starts 658 clocks later.
- `VGA_FRAME_CNT_EN`: run 3 frames → `frame_cnt` reads 0, 1, 2 at successive `frame_start` pulses. Build without the macro → the port is absent and the other checks pass unchanged.
